// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - key-driven program loader for the instruction memory write port
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              wr_key_i,
    input  logic              done_key_i,
    input  logic [DATA_W-1:0] sw_data_i,
    output logic              mem_wren_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              cpu_run_o,
    output logic              busy_o,
    output logic              full_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic [DATA_W-1:0] checksum_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        RUN   = 2'd3
    } state_t;

    // One word past the last address: the count value that means "memory full".
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q;
    logic              start_prev_q;
    logic              wr_prev_q;
    logic              done_prev_q;
    logic              done_pend_q;
    logic              mem_wren_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              cpu_run_q;
    logic [ADDR_W:0]   word_count_q;
    logic [DATA_W-1:0] checksum_q;

    logic              start_edge;
    logic              wr_edge;
    logic              done_edge;
    logic              full;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [ADDR_W:0]   word_count_d;
    logic [DATA_W-1:0] checksum_d;

    assign start_edge = start_i    & ~start_prev_q;
    assign wr_edge    = wr_key_i   & ~wr_prev_q;
    assign done_edge  = done_key_i & ~done_prev_q;

    assign full = (word_count_q == DEPTH);

    // Values the write bookkeeping takes at the end of a WRITE cycle; the
    // address wraps naturally at its own width.
    always_comb begin
        mem_addr_d   = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        word_count_d = word_count_q + {{ADDR_W{1'b0}}, 1'b1};
        checksum_d   = checksum_q + mem_data_q;
    end

    // Previous key levels; reset high so a key held through reset is not an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            start_prev_q <= 1'b1;
            wr_prev_q    <= 1'b1;
            done_prev_q  <= 1'b1;
        end else begin
            start_prev_q <= start_i;
            wr_prev_q    <= wr_key_i;
            done_prev_q  <= done_key_i;
        end
    end

    // Load session state machine with registered memory-port and status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            done_pend_q  <= 1'b0;
            mem_wren_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            cpu_run_q    <= 1'b0;
            word_count_q <= '0;
            checksum_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_q      <= LOAD;
                        mem_addr_q   <= '0;
                        word_count_q <= '0;
                        checksum_q   <= '0;
                        done_pend_q  <= 1'b0;
                    end
                end

                LOAD: begin
                    if (start_edge) begin
                        // Restart wins over any same-cycle write or done request.
                        mem_addr_q   <= '0;
                        word_count_q <= '0;
                        checksum_q   <= '0;
                        done_pend_q  <= 1'b0;
                    end else if (wr_edge) begin
                        if (!full) begin
                            mem_data_q  <= sw_data_i;
                            mem_wren_q  <= 1'b1;
                            done_pend_q <= done_edge;
                            state_q     <= WRITE;
                        end
                    end else if (done_edge) begin
                        cpu_run_q <= 1'b1;
                        state_q   <= RUN;
                    end
                end

                WRITE: begin
                    // Single-cycle strobe; bookkeeping commits as it ends.
                    mem_wren_q   <= 1'b0;
                    mem_addr_q   <= mem_addr_d;
                    word_count_q <= word_count_d;
                    checksum_q   <= checksum_d;
                    done_pend_q  <= 1'b0;
                    if (done_pend_q || done_edge) begin
                        cpu_run_q <= 1'b1;
                        state_q   <= RUN;
                    end else begin
                        state_q <= LOAD;
                    end
                end

                RUN: begin
                    if (start_edge) begin
                        cpu_run_q    <= 1'b0;
                        state_q      <= LOAD;
                        mem_addr_q   <= '0;
                        word_count_q <= '0;
                        checksum_q   <= '0;
                        done_pend_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q    <= IDLE;
                    mem_wren_q <= 1'b0;
                    cpu_run_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_wren_o   = mem_wren_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign cpu_run_o    = cpu_run_q;
    assign busy_o       = (state_q == LOAD) || (state_q == WRITE);
    assign full_o       = full;
    assign word_count_o = word_count_q;
    assign checksum_o   = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic              wr_key;
    logic              done_key;
    logic [DATA_W-1:0] sw_data;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              cpu_run;
    logic              busy;
    logic              full;
    logic [ADDR_W:0]   word_count;
    logic [DATA_W-1:0] checksum;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .wr_key_i     (wr_key),
        .done_key_i   (done_key),
        .sw_data_i    (sw_data),
        .mem_wren_o   (mem_wren),
        .mem_addr_o   (mem_addr),
        .mem_data_o   (mem_data),
        .cpu_run_o    (cpu_run),
        .busy_o       (busy),
        .full_o       (full),
        .word_count_o (word_count),
        .checksum_o   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0]        exp_addr  = '0;
    int                       exp_count = 0;
    logic                     wren_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        exp_addr  = '0;
        exp_count = 0;
        tick(1);
    endtask

    task automatic press_wr(input logic [DATA_W-1:0] d);
        sw_data = d;
        wr_key  = 1'b1;
        if (exp_count < DEPTH) begin
            exp_q.push_back({exp_addr, d});
            exp_addr  = exp_addr + 1'b1;
            exp_count = exp_count + 1;
        end
        tick(1);
        wr_key = 1'b0;
        tick(1);
    endtask

    // Every write strobe is checked against the scoreboard and for one-cycle width.
    always @(negedge clk) begin
        if (mem_wren === 1'b1) begin
            logic [ADDR_W+DATA_W-1:0] e;
            chk("wren_width", 32'(wren_prev), 32'd0);
            chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                chk("wr_data", 32'(mem_data), 32'(e[DATA_W-1:0]));
            end
        end
        wren_prev = (mem_wren === 1'b1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        wr_key   = 1'b1;
        done_key = 1'b0;
        sw_data  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick(3);
        chk("rst_wren",    32'(mem_wren),   32'd0);
        chk("rst_addr",    32'(mem_addr),   32'd0);
        chk("rst_data",    32'(mem_data),   32'd0);
        chk("rst_run",     32'(cpu_run),    32'd0);
        chk("rst_busy",    32'(busy),       32'd0);
        chk("rst_full",    32'(full),       32'd0);
        chk("rst_count",   32'(word_count), 32'd0);
        chk("rst_cksum",   32'(checksum),   32'd0);
        wr_key = 1'b0;
        tick(1);

        // Basic load of two words followed by done.
        start_pulse();
        chk("basic_busy", 32'(busy), 32'd1);
        press_wr(16'h1234);
        press_wr(16'h0F0F);
        chk("basic_run_pre", 32'(cpu_run), 32'd0);
        done_key = 1'b1;
        tick(1);
        done_key = 1'b0;
        chk("basic_run",   32'(cpu_run),    32'd1);
        chk("basic_busy0", 32'(busy),       32'd0);
        chk("basic_count", 32'(word_count), 32'd2);
        chk("basic_cksum", 32'(checksum),   32'h2143);
        chk("basic_addr",  32'(mem_addr),   32'd2);
        tick(1);

        // Write and done edges in the same cycle.
        start_pulse();
        sw_data  = 16'hABCD;
        wr_key   = 1'b1;
        done_key = 1'b1;
        exp_q.push_back({exp_addr, 16'hABCD});
        exp_addr  = exp_addr + 1'b1;
        exp_count = exp_count + 1;
        tick(1);
        wr_key   = 1'b0;
        done_key = 1'b0;
        chk("simul_run_early", 32'(cpu_run), 32'd0);
        tick(1);
        chk("simul_run",   32'(cpu_run),    32'd1);
        chk("simul_count", 32'(word_count), 32'd1);
        chk("simul_cksum", 32'(checksum),   32'hABCD);

        // Done edge arriving during the WRITE cycle.
        start_pulse();
        sw_data = 16'h1111;
        wr_key  = 1'b1;
        exp_q.push_back({exp_addr, 16'h1111});
        exp_addr  = exp_addr + 1'b1;
        exp_count = exp_count + 1;
        tick(1);
        wr_key   = 1'b0;
        done_key = 1'b1;
        tick(1);
        done_key = 1'b0;
        chk("pend_run",   32'(cpu_run),    32'd1);
        chk("pend_count", 32'(word_count), 32'd1);
        tick(1);

        // Restart from RUN after three writes.
        start_pulse();
        press_wr(16'h0001);
        press_wr(16'h0002);
        press_wr(16'h0003);
        done_key = 1'b1;
        tick(1);
        done_key = 1'b0;
        chk("rs_run",   32'(cpu_run),    32'd1);
        chk("rs_count", 32'(word_count), 32'd3);
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        exp_addr  = '0;
        exp_count = 0;
        chk("rs_run_fall", 32'(cpu_run),    32'd0);
        chk("rs_count0",   32'(word_count), 32'd0);
        chk("rs_cksum0",   32'(checksum),   32'd0);
        chk("rs_busy",     32'(busy),       32'd1);
        tick(1);
        press_wr(16'h5555);
        chk("rs_count1", 32'(word_count), 32'd1);

        // Fill the whole memory with 0xFFFF.
        start_pulse();
        for (int i = 0; i < DEPTH - 1; i++) press_wr(16'hFFFF);
        chk("full_pre", 32'(full), 32'd0);
        press_wr(16'hFFFF);
        chk("full_set",   32'(full),       32'd1);
        chk("full_addr",  32'(mem_addr),   32'd0);
        chk("full_count", 32'(word_count), 32'd1024);
        chk("full_cksum", 32'(checksum),   32'hFC00);
        press_wr(16'h1234);
        chk("full_count2", 32'(word_count), 32'd1024);
        chk("full_cksum2", 32'(checksum),   32'hFC00);
        chk("full_busy",   32'(busy),       32'd1);

        // Reset asserted in the middle of a WRITE cycle.
        start_pulse();
        sw_data = 16'h7777;
        wr_key  = 1'b1;
        exp_q.push_back({exp_addr, 16'h7777});
        exp_addr  = exp_addr + 1'b1;
        exp_count = exp_count + 1;
        tick(1);
        chk("mw_wren_hi", 32'(mem_wren), 32'd1);
        #6 rst = 1'b1;
        #1;
        chk("mw_wren_drop", 32'(mem_wren), 32'd0);
        wr_key = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("mw_count", 32'(word_count), 32'd0);
        chk("mw_busy",  32'(busy),       32'd0);
        chk("mw_run",   32'(cpu_run),    32'd0);
        chk("mw_addr",  32'(mem_addr),   32'd0);

        tick(2);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes 16-bit instruction words into the 1024x16 instruction memory before the pipeline runs. It is the write side of the instruction-memory port that the fetch stage reads. The loader takes operator-entered words from the switches on debounced key strokes and writes them at consecutive addresses from 0. It releases the CPU through `cpu_run` and reports a running word count and checksum for the 7-segment display.

## Interface
- `ADDR_W`, 10: memory address width; depth = 2^ADDR_W.
- `DATA_W`, 16: instruction word width.

- `clk`  in  1  system clock (CLOCK_50 domain).
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  debounced level. A rising edge opens a load session.
- `wr_key`  in  1  debounced level. A rising edge commits `sw_data`.
- `done_key`  in  1  debounced level. A rising edge ends the session.
- `sw_data`  in  DATA_W  instruction word from the switches.
- `mem_wren`  out  1  memory write enable, a one-cycle pulse.
- `mem_addr`  out  ADDR_W  memory write address.
- `mem_data`  out  DATA_W  memory write data.
- `cpu_run`  out  1  high while the CPU may fetch.
- `busy`  out  1  high in LOAD and WRITE.
- `full`  out  1  high once all 2^ADDR_W words have been written.
- `word_count`  out  ADDR_W+1  number of words written this session.
- `checksum`  out  DATA_W  sum of the written words, mod 2^DATA_W.

## Operation
- **Edge detection.** Each key input has a previous-value register. edge = level & ~prev.
  - All prev registers reset to 1, so a key held through reset produces no edge.
- **FSM states:** IDLE, LOAD, WRITE, RUN.
- **IDLE**
  - On a `start` edge: go to LOAD; clear `mem_addr`, `word_count` and `checksum`.
  - `wr_key` and `done_key` edges are ignored.
- **LOAD**
  - On a `wr_key` edge with `full`=0: capture `sw_data` into `mem_data` and go to WRITE.
  - On a `wr_key` edge with `full`=1: ignore the edge and stay in LOAD.
  - On a `done_key` edge with no `wr_key` edge: go to RUN.
  - On a `start` edge: restart the session. Clear `mem_addr`, `word_count` and `checksum`; any same-cycle `wr_key` or `done_key` edge is dropped.
- **WRITE** lasts exactly one cycle.
  - `mem_wren`=1.
  - At the end of the cycle:
    - `mem_addr` += 1, wrapping to 0 after 2^ADDR_W-1.
    - `word_count` += 1.
    - `checksum` += `mem_data`, truncated to DATA_W.
  - Next state is RUN if a done request is pending, else LOAD.
  - A done request is pending if a `done_key` edge arrived in the same cycle as the `wr_key` edge or during WRITE. It is held in a one-bit pending flag.
- **RUN**
  - `cpu_run`=1; the memory is not written.
  - On a `start` edge: go to LOAD, clearing as in IDLE.
  - `cpu_run` falls on the same clock edge as that transition.
- **`full`** = (`word_count` == 2^ADDR_W). It is combinational from `word_count`.
- **Port mux.** When `mem_wren`=0, `mem_addr` and `mem_data` hold their last values. The top level muxes the fetch PC onto the memory address only when `cpu_run`=1.

## Timing
- **Reset values:** state IDLE; `mem_wren`=0, `mem_addr`=0, `mem_data`=0, `cpu_run`=0, `busy`=0, `full`=0, `word_count`=0, `checksum`=0.
- All outputs are registered, except `full` and `busy`, which decode from registered state and count.
- **Write latency.** Let the `wr_key` level first be sampled high at edge n (prev low). Then:
  - `mem_wren` is high for cycle n to n+1;
  - `mem_addr` and `mem_data` are stable throughout that cycle;
  - `mem_addr`, `word_count` and `checksum` update at edge n+1.
- **Throughput:** at most one write per key press; the minimum spacing is 2 cycles (LOAD to WRITE to LOAD).
- **Done latency.** A `done_key` edge at edge n in LOAD gives `cpu_run`=1 from edge n+1. If the edge coincides with a write, `cpu_run`=1 from edge n+2, after the write completes.
- **Reset during WRITE:** `mem_wren` drops immediately (asynchronously) and no partial increment occurs.

## Test plan
- **Reset with keys held:** reset with `wr_key`=1 held, then release reset -> no `mem_wren` pulse; all outputs 0; state IDLE.
- **Basic load:** `start` edge; write 0x1234, then 0x0F0F, then `done_key` -> two `mem_wren` pulses, each exactly 1 cycle.
  - First pulse: addr 0, data 0x1234. Second pulse: addr 1, data 0x0F0F.
  - Afterwards: `word_count`=2, `checksum`=0x2143, `cpu_run`=1 one cycle after the done edge.
- **Simultaneous edges:** `wr_key` and `done_key` edges in the same cycle with `sw_data`=0xABCD -> one write at addr 0; `cpu_run`=1 two cycles later; `word_count`=1.
- **Full memory and checksum wrap:** 1024 writes of 0xFFFF -> `full`=1; `mem_addr` wraps to 0; `checksum`=0xFC00 (1024 x 0xFFFF mod 2^16). A 1025th `wr_key` edge gives no `mem_wren`.
- **Restart:** `start` edge in RUN after 3 writes -> `cpu_run` falls at the same edge; `word_count`=0, `checksum`=0; the next write goes to addr 0.
- **Mid-write reset:** assert `rst` during the WRITE cycle -> `mem_wren`=0 immediately; after release `word_count`=0 and state IDLE.
